if_id_stage_controller: RTL and testbench

//   Owns the IF/ID pipeline register that feeds instruction field decode, and sequences it.
//   - Captures fetched instruction/PC.
//   - Detects load-use hazards against the EX stage and stalls.
//   - Squashes wrong-path fetches after a taken branch.
//   - Freezes the front end while a downstream unit is busy.
//   - Drives fetch PC write-enable and the ID/EX bubble request.

---
 rtl/if_id_stage_controller.sv | 186 ++++++++++++++++++
 tb/tb_if_id_stage_controller.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_controller.sv
// if_id_stage_controller
//   Owns the IF/ID pipeline register and decides each cycle whether it
//   captures a new fetch, holds for a load-use hazard, freezes for a busy
//   back end, or is squashed after a taken branch.
//   Optional feature: define IF_ID_STALL_COUNT_EN to add the stall_count
//   output, a saturating count of cycles in which fetch was held
//   (pc_write low).
module if_id_stage_controller #(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] fetch_instr,
   input  logic [31:0] fetch_pc,
   input  logic        fetch_valid,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        branch_taken,
   input  logic        downstream_busy,
   output logic [31:0] instruction_if_id,
   output logic [31:0] pc_if_id,
   output logic        id_valid,
   output logic        pc_write,
   output logic        id_ex_bubble
`ifdef IF_ID_STALL_COUNT_EN
   ,
   output logic [31:0] stall_count
`endif
);

   // FLUSH_CYCLES is at most 15, so the remaining-discard counter fits in 4 bits.
   localparam int unsigned       CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       pc_q, pc_d;
   logic              valid_q, valid_d;

   logic [5:0]        id_op;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic              id_uses_rt;
   logic              hazard;

   // Exactly one of these is high every cycle; they encode the priority order.
   logic              act_branch;
   logic              act_freeze;
   logic              act_stall;
   logic              act_discard;
   logic              act_capture;

   // Decode the ID instruction fields and detect a load-use dependency on EX.
   always_comb begin
      id_op      = instr_q[31:26];
      id_rs      = instr_q[25:21];
      id_rt      = instr_q[20:16];
      // R-type, beq/bne and stores read rt as a source; loads and immediates do not.
      id_uses_rt = (id_op == 6'h00) || (id_op == 6'h04) || (id_op == 6'h05) ||
                   ((id_op >= 6'h28) && (id_op <= 6'h2B));
      hazard     = valid_q && ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   end

   // Classify the cycle: branch beats busy, busy beats hazard, hazard only matters in RUN.
   always_comb begin
      act_branch  = branch_taken;
      act_freeze  = !branch_taken && downstream_busy;
      act_stall   = !branch_taken && !downstream_busy && (state_q == ST_RUN) && hazard;
      act_discard = !branch_taken && !downstream_busy && (state_q == ST_FLUSH);
      act_capture = !branch_taken && !downstream_busy && (state_q == ST_RUN) && !hazard;
   end

   // State register: RUN/FLUSH and the remaining-discard counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: a branch (re)starts the flush, a discard cycle counts it down.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (act_branch) begin
         state_d = ST_FLUSH;
         cnt_d   = CNT_LOAD;
      end else if (act_discard) begin
         if (cnt_q == '0) begin
            state_d = ST_RUN;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Pipeline register: the IF/ID instruction, its PC and the valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= NOP_WORD;
         pc_q    <= 32'h0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   // Next pipeline register contents: squash, hold, or capture the fetch.
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (act_branch || act_discard) begin
         instr_d = NOP_WORD;
         valid_d = 1'b0;
      end else if (act_capture) begin
         instr_d = fetch_valid ? fetch_instr : NOP_WORD;
         valid_d = fetch_valid;
         // PC is left alone on an empty slot so it keeps naming the last real instruction.
         if (fetch_valid) begin
            pc_d = fetch_pc;
         end
      end
   end

   // Combinational control outputs; reset forces "advance fetch, bubble EX".
   always_comb begin
      pc_write     = 1'b1;
      id_ex_bubble = 1'b1;
      if (rst_n) begin
         if (act_freeze) begin
            // EX/MEM hold themselves, so no bubble is inserted.
            pc_write     = 1'b0;
            id_ex_bubble = 1'b0;
         end else if (act_stall) begin
            pc_write     = 1'b0;
            id_ex_bubble = 1'b1;
         end else if (act_capture) begin
            pc_write     = 1'b1;
            id_ex_bubble = !valid_q;
         end
      end
   end

   assign instruction_if_id = instr_q;
   assign pc_if_id          = pc_q;
   assign id_valid          = valid_q;

`ifdef IF_ID_STALL_COUNT_EN
   logic [31:0] stall_count_q, stall_count_d;

   // Saturating count of cycles in which fetch was not allowed to advance.
   always_comb begin
      stall_count_d = stall_count_q;
      if (!pc_write && (stall_count_q != 32'hFFFF_FFFF)) begin
         stall_count_d = stall_count_q + 32'd1;
      end
   end

   // Stall counter register; cleared only by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_q <= 32'h0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_if_id_stage_controller.sv
// tb_if_id_stage_controller
//   Directed scenarios plus randomized traffic for if_id_stage_controller.
//   The reference model tracks the ID slot and the number of discard slots
//   still owed after a branch.
module tb_if_id_stage_controller;

   localparam int unsigned FC  = 2;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        ex_valid;
   logic        ex_mem_read;
   logic [4:0]  ex_rt;
   logic        branch_taken;
   logic        downstream_busy;
   logic [31:0] instruction_if_id;
   logic [31:0] pc_if_id;
   logic        id_valid;
   logic        pc_write;
   logic        id_ex_bubble;
`ifdef IF_ID_STALL_COUNT_EN
   logic [31:0] stall_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   if_id_stage_controller #(
      .FLUSH_CYCLES (FC),
      .NOP_WORD     (NOP)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .fetch_instr       (fetch_instr),
      .fetch_pc          (fetch_pc),
      .fetch_valid       (fetch_valid),
      .ex_valid          (ex_valid),
      .ex_mem_read       (ex_mem_read),
      .ex_rt             (ex_rt),
      .branch_taken      (branch_taken),
      .downstream_busy   (downstream_busy),
      .instruction_if_id (instruction_if_id),
      .pc_if_id          (pc_if_id),
      .id_valid          (id_valid),
      .pc_write          (pc_write),
      .id_ex_bubble      (id_ex_bubble)
`ifdef IF_ID_STALL_COUNT_EN
      ,
      .stall_count       (stall_count)
`endif
   );

   // ---------------- reference model ----------------
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic        m_valid;
   int          m_left;     // wrong-path slots still to discard
   logic        m_pw_now;
   logic        m_hz_now;
`ifdef IF_ID_STALL_COUNT_EN
   logic [31:0] m_stalls;
`endif

   function automatic logic m_hz();
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       reads_rt;
      op       = m_instr[31:26];
      rs       = m_instr[25:21];
      rt       = m_instr[20:16];
      reads_rt = op inside {6'h00, 6'h04, 6'h05, [6'h28:6'h2B]};
      return m_valid && ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
             ((ex_rt == rs) || (reads_rt && (ex_rt == rt)));
   endfunction

   function automatic logic exp_pc_write();
      if (!rst_n || branch_taken) return 1'b1;
      if (downstream_busy) return 1'b0;
      return !m_hz();
   endfunction

   function automatic logic exp_bubble();
      if (!rst_n || branch_taken) return 1'b1;
      if (downstream_busy) return 1'b0;
      // A discarding slot is never valid, and a hazard needs a valid ID slot.
      return !m_valid || m_hz();
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_instr = NOP;
         m_pc    = 32'h0;
         m_valid = 1'b0;
         m_left  = 0;
`ifdef IF_ID_STALL_COUNT_EN
         m_stalls = 32'h0;
`endif
      end else begin
         m_pw_now = exp_pc_write();
         m_hz_now = m_hz();
`ifdef IF_ID_STALL_COUNT_EN
         if (!m_pw_now && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
`endif
         if (branch_taken) begin
            m_instr = NOP;
            m_valid = 1'b0;
            m_left  = FC;
         end else if (downstream_busy || m_hz_now) begin
            // slot holds
         end else if (m_left > 0) begin
            m_instr = NOP;
            m_valid = 1'b0;
            m_left  = m_left - 1;
         end else begin
            m_valid = fetch_valid;
            m_instr = fetch_valid ? fetch_instr : NOP;
            if (fetch_valid) m_pc = fetch_pc;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive_idle();
      fetch_valid     = 1'b0;
      fetch_instr     = 32'h0;
      fetch_pc        = 32'h0;
      ex_valid        = 1'b0;
      ex_mem_read     = 1'b0;
      ex_rt           = 5'd0;
      branch_taken    = 1'b0;
      downstream_busy = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      drive_idle();
      downstream_busy = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (instruction_if_id !== NOP) begin n_fail++; $display("FAIL reset_instr got=%h exp=%h", instruction_if_id, NOP); end
      n_checks++; if (pc_if_id !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", pc_if_id, 32'h0); end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL reset_pc_write got=%b exp=1", pc_write); end
      n_checks++; if (id_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble got=%b exp=1", id_ex_bubble); end
`ifdef IF_ID_STALL_COUNT_EN
      n_checks++; if (stall_count !== 32'h0) begin n_fail++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
`endif
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_capture();
      fetch_valid = 1'b1; fetch_instr = 32'h0123_4820; fetch_pc = 32'h40;
      @(negedge clk);
      drive_idle();
      #1;
      n_checks++; if (instruction_if_id !== 32'h0123_4820) begin n_fail++; $display("FAIL cap_instr got=%h exp=%h", instruction_if_id, 32'h0123_4820); end
      n_checks++; if (pc_if_id !== 32'h40) begin n_fail++; $display("FAIL cap_pc got=%h exp=%h", pc_if_id, 32'h40); end
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL cap_valid got=%b exp=1", id_valid); end
      n_checks++; if (id_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL cap_bubble got=%b exp=0", id_ex_bubble); end
      @(negedge clk);
      #1;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL empty_valid got=%b exp=0", id_valid); end
      n_checks++; if (pc_if_id !== 32'h40) begin n_fail++; $display("FAIL empty_pc_hold got=%h exp=%h", pc_if_id, 32'h40); end
      n_checks++; if (instruction_if_id !== NOP) begin n_fail++; $display("FAIL empty_instr got=%h exp=%h", instruction_if_id, NOP); end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      drive_idle();
      fetch_valid = 1'b1; fetch_instr = 32'h0109_5020; fetch_pc = 32'h44;
      @(negedge clk);
      fetch_instr = 32'h2000_0001; fetch_pc = 32'h48;
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8;
      #1;
      n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL lu_pc_write got=%b exp=0", pc_write); end
      n_checks++; if (id_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble got=%b exp=1", id_ex_bubble); end
      @(negedge clk);
      // The bubble is now in EX, so the load has moved on.
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
      #1;
      n_checks++; if (instruction_if_id !== 32'h0109_5020) begin n_fail++; $display("FAIL lu_hold got=%h exp=%h", instruction_if_id, 32'h0109_5020); end
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL lu_hold_valid got=%b exp=1", id_valid); end
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_release_pw got=%b exp=1", pc_write); end
      n_checks++; if (id_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_release_bubble got=%b exp=0", id_ex_bubble); end
      @(negedge clk);
      #1;
      n_checks++; if (instruction_if_id !== 32'h2000_0001) begin n_fail++; $display("FAIL lu_next got=%h exp=%h", instruction_if_id, 32'h2000_0001); end
      fetch_instr = 32'h0109_5020; fetch_pc = 32'h4C;
      @(negedge clk);
      fetch_instr = 32'h2000_0002; fetch_pc = 32'h50;
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd0;
      #1;
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_r0_pw got=%b exp=1", pc_write); end
      n_checks++; if (id_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL lu_r0_bubble got=%b exp=0", id_ex_bubble); end
      @(negedge clk);
      drive_idle();
      #1;
      n_checks++; if (instruction_if_id !== 32'h2000_0002) begin n_fail++; $display("FAIL lu_r0_adv got=%h exp=%h", instruction_if_id, 32'h2000_0002); end
   endtask

   task automatic test_store_hazard();
      @(negedge clk);
      drive_idle();
      fetch_valid = 1'b1; fetch_instr = 32'hAD09_0004; fetch_pc = 32'h60;
      @(negedge clk);
      fetch_valid = 1'b0;
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9;
      #1;
      n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL sw_pw got=%b exp=0", pc_write); end
      n_checks++; if (id_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL sw_bubble got=%b exp=1", id_ex_bubble); end
      @(negedge clk);
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
      fetch_valid = 1'b1; fetch_instr = 32'h8D09_0004; fetch_pc = 32'h64;
      @(negedge clk);
      fetch_valid = 1'b0;
      ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9;
      #1;
      n_checks++; if (instruction_if_id !== 32'h8D09_0004) begin n_fail++; $display("FAIL lw_instr got=%h exp=%h", instruction_if_id, 32'h8D09_0004); end
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL lw_pw got=%b exp=1", pc_write); end
      n_checks++; if (id_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL lw_bubble got=%b exp=0", id_ex_bubble); end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic test_branch_flush();
      @(negedge clk);
      drive_idle();
      fetch_valid = 1'b1; branch_taken = 1'b1;
      fetch_instr = 32'hA000_0000; fetch_pc = 32'h100;
      #1;
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL br_pw got=%b exp=1", pc_write); end
      n_checks++; if (id_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL br_bubble got=%b exp=1", id_ex_bubble); end
      for (int c = 0; c <= int'(FC); c++) begin
         @(negedge clk);
         branch_taken = 1'b0;
         fetch_instr  = 32'hA000_0000 + 32'(c + 1);
         fetch_pc     = 32'h100 + 32'(4 * (c + 1));
         #1;
         n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL br_discard%0d_valid got=%b exp=0", c, id_valid); end
         n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL br_discard%0d_pw got=%b exp=1", c, pc_write); end
         n_checks++; if (id_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL br_discard%0d_bubble got=%b exp=1", c, id_ex_bubble); end
      end
      @(negedge clk);
      drive_idle();
      #1;
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL br_resume_valid got=%b exp=1", id_valid); end
      n_checks++; if (instruction_if_id !== 32'hA000_0000 + 32'(FC + 1)) begin n_fail++; $display("FAIL br_resume_instr got=%h exp=%h", instruction_if_id, 32'hA000_0000 + 32'(FC + 1)); end
   endtask

   task automatic test_busy_flush();
`ifdef IF_ID_STALL_COUNT_EN
      logic [31:0] sc0;
`endif
      @(negedge clk);
      drive_idle();
      fetch_valid = 1'b1; fetch_instr = 32'hB000_0000; branch_taken = 1'b1;
      @(negedge clk);
      branch_taken = 1'b0; downstream_busy = 1'b1;
`ifdef IF_ID_STALL_COUNT_EN
      sc0 = stall_count;
`endif
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL busy%0d_pw got=%b exp=0", k, pc_write); end
         n_checks++; if (id_ex_bubble !== 1'b0) begin n_fail++; $display("FAIL busy%0d_bubble got=%b exp=0", k, id_ex_bubble); end
         @(negedge clk);
      end
      downstream_busy = 1'b0;
      #1;
`ifdef IF_ID_STALL_COUNT_EN
      n_checks++; if (stall_count !== sc0 + 32'd3) begin n_fail++; $display("FAIL busy_stall_count got=%0d exp=%0d", stall_count, sc0 + 32'd3); end
`endif
      // The frozen flush must still owe its full set of discard slots.
      for (int k = 0; k < int'(FC); k++) begin
         fetch_instr = 32'hB000_0010 + 32'(k);
         #1;
         n_checks++; if (id_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL busy_discard%0d_bubble got=%b exp=1", k, id_ex_bubble); end
         @(negedge clk);
         #1;
         n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL busy_discard%0d_valid got=%b exp=0", k, id_valid); end
      end
      fetch_instr = 32'hB000_00FF;
      @(negedge clk);
      #1;
      n_checks++; if (instruction_if_id !== 32'hB000_00FF) begin n_fail++; $display("FAIL busy_resume_instr got=%h exp=%h", instruction_if_id, 32'hB000_00FF); end
      branch_taken = 1'b1; downstream_busy = 1'b1;
      #1;
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL br_over_busy_pw got=%b exp=1", pc_write); end
      n_checks++; if (id_ex_bubble !== 1'b1) begin n_fail++; $display("FAIL br_over_busy_bubble got=%b exp=1", id_ex_bubble); end
      @(negedge clk);
      drive_idle();
      #1;
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL br_over_busy_valid got=%b exp=0", id_valid); end
      repeat (FC + 1) @(negedge clk);
   endtask

   task automatic test_reset_mid_flush();
      @(negedge clk);
      drive_idle();
      fetch_valid = 1'b1; fetch_instr = 32'h1111_0000; branch_taken = 1'b1;
      @(negedge clk);
      branch_taken = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++; if (instruction_if_id !== NOP) begin n_fail++; $display("FAIL rmf_instr got=%h exp=%h", instruction_if_id, NOP); end
      n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_valid got=%b exp=0", id_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      fetch_valid = 1'b1; fetch_instr = 32'h2222_0000; fetch_pc = 32'h80;
      @(negedge clk);
      drive_idle();
      #1;
      n_checks++; if (instruction_if_id !== 32'h2222_0000) begin n_fail++; $display("FAIL rmf_capture got=%h exp=%h", instruction_if_id, 32'h2222_0000); end
      n_checks++; if (id_valid !== 1'b1) begin n_fail++; $display("FAIL rmf_capture_valid got=%b exp=1", id_valid); end
      n_checks++; if (pc_if_id !== 32'h80) begin n_fail++; $display("FAIL rmf_capture_pc got=%h exp=%h", pc_if_id, 32'h80); end
   endtask

   task automatic test_random();
      logic [5:0] ops [8];
      logic       e_pw;
      logic       e_bub;
      ops = '{6'h00, 6'h04, 6'h05, 6'h28, 6'h2B, 6'h23, 6'h08, 6'h2A};
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         fetch_valid     = ($urandom_range(0, 3) != 0);
         fetch_instr     = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)), 16'($urandom)};
         fetch_pc        = $urandom & 32'hFFFF_FFFC;
         ex_valid        = ($urandom_range(0, 3) != 0);
         ex_mem_read     = $urandom_range(0, 1) == 1;
         ex_rt           = 5'($urandom_range(0, 3));
         branch_taken    = ($urandom_range(0, 11) == 0);
         downstream_busy = ($urandom_range(0, 5) == 0);
         #1;
         e_pw  = exp_pc_write();
         e_bub = exp_bubble();
         n_checks++; if (instruction_if_id !== m_instr) begin n_fail++; $display("FAIL rnd%0d_instr got=%h exp=%h", n, instruction_if_id, m_instr); end
         n_checks++; if (pc_if_id !== m_pc) begin n_fail++; $display("FAIL rnd%0d_pc got=%h exp=%h", n, pc_if_id, m_pc); end
         n_checks++; if (id_valid !== m_valid) begin n_fail++; $display("FAIL rnd%0d_valid got=%b exp=%b", n, id_valid, m_valid); end
         n_checks++; if (pc_write !== e_pw) begin n_fail++; $display("FAIL rnd%0d_pw got=%b exp=%b", n, pc_write, e_pw); end
         n_checks++; if (id_ex_bubble !== e_bub) begin n_fail++; $display("FAIL rnd%0d_bubble got=%b exp=%b", n, id_ex_bubble, e_bub); end
`ifdef IF_ID_STALL_COUNT_EN
         n_checks++; if (stall_count !== m_stalls) begin n_fail++; $display("FAIL rnd%0d_stall_count got=%0d exp=%0d", n, stall_count, m_stalls); end
`endif
      end
      @(negedge clk);
      drive_idle();
   endtask

   initial begin
      drive_idle();
      rst_n = 1'b0;
      test_reset();
      test_capture();
      test_load_use();
      test_store_hazard();
      test_branch_flush();
      test_busy_flush();
      test_reset_mid_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
